// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   mdu_op_e    : RV32M unsigned operation select (MUL, MULHU, DIVU, REMU)
//   mdu_state_e : sequencer control states
//   ALU_*       : 2-bit ALU control encodings, shared with the decoder
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_REMU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/mdu_sequencer.sv
// Iterative RV32M unsigned MUL/MULHU/DIVU/REMU controller that borrows the
// shared external ALU for one add or subtract per clock, DATA_WIDTH cycles.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, op, src_a, src_b  request and operands, sampled when ready=1
//   abort                    kills an operation in RUN (no done, result kept)
//   ready, busy, done        IDLE / RUN / one-cycle completion pulse
//   result                   registered result, held until next completion
//   alu_op_a, alu_op_b       ALU operand drive (zero outside RUN)
//   alu_control              ALU function (add for multiply, sub for divide)
//   alu_result, alu_cout     ALU sum/difference and raw carry-out
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  abort,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  output logic [1:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cout
);

  mdu_state_e            state_q, state_d;
  mdu_op_e               op_q;
  logic [CNT_W-1:0]      cnt_q;
  // acc_q  : product high half (hi) or partial remainder (rem)
  // lo_q   : multiplier / product low half (lo) or dividend / quotient (quo)
  // opnd_q : multiplicand (mcand) or divisor (dvs)
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  is_div;
  logic                  last_iter;

  assign is_div    = op_q[1];
  assign last_iter = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  // Remainder shifted left with the next dividend bit pulled in.
  assign shifted   = {acc_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};
  assign result    = result_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks the final-iteration exit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)          state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: status flags and ALU drive
  always_comb begin
    ready       = (state_q == IDLE);
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    alu_op_a    = '0;
    alu_op_b    = '0;
    alu_control = ALU_ADD;
    if (state_q == RUN) begin
      if (is_div) begin
        alu_op_a    = shifted;
        alu_op_b    = opnd_q;
        alu_control = ALU_SUB;
      end else begin
        alu_op_a    = acc_q;
        alu_op_b    = lo_q[0] ? opnd_q : '0;
        alu_control = ALU_ADD;
      end
    end
  end

  // Per-iteration update of the working registers from the ALU response
  always_comb begin
    acc_d = acc_q;
    lo_d  = lo_q;
    if (is_div) begin
      // Carry-out of the subtract means no borrow: the quotient bit is 1.
      acc_d = alu_cout ? alu_result : shifted;
      lo_d  = {lo_q[DATA_WIDTH-2:0], alu_cout};
    end else begin
      // 33-bit sum shifted right: carry enters hi, sum LSB enters lo.
      acc_d = {alu_cout, alu_result[DATA_WIDTH-1:1]};
      lo_d  = {alu_result[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MDU_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= mdu_op_e'(op);
            cnt_q <= '0;
            acc_q <= '0;
            if (op[1]) begin
              lo_q   <= src_a;
              opnd_q <= src_b;
            end else begin
              lo_q   <= src_b;
              opnd_q <= src_a;
            end
          end
        end
        RUN: begin
          if (!abort) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            // op[0] set (MULHU, REMU) selects the acc half
            if (last_iter) result_q <= op_q[0] ? acc_d : lo_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        abort = 1'b0;
  logic        ready, busy, done;
  logic [31:0] result;
  logic [31:0] alu_op_a, alu_op_b, alu_result;
  logic [1:0]  alu_control;
  logic        alu_cout;
  logic [32:0] alu_sum;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          acc;
    string       name;
  } exp_t;
  exp_t sb[$];

  mdu_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .abort(abort), .ready(ready), .busy(busy), .done(done), .result(result),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // External ALU: add, or subtract as a + ~b + 1 with raw carry-out.
  always_comb begin
    if (alu_control == 2'b01) alu_sum = {1'b0, alu_op_a} + {1'b0, ~alu_op_b} + 33'd1;
    else                      alu_sum = {1'b0, alu_op_a} + {1'b0, alu_op_b};
  end
  assign alu_result = alu_sum[31:0];
  assign alu_cout   = alu_sum[32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops the oldest expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done");
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        // accepting edge to the edge that raises done: 32 edges apart
        check({e.name, "_latency"}, cyc - e.acc, 32);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input bit expect_done);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_wait"}, {31'b0, ready}, 32'd1);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (expect_done) sb.push_back('{exp, cyc + 1, name});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name, input logic [1:0] ctl);
    int nbusy = 0;
    int bad = 0;
    int n = 0;
    issue(o, a, b, exp, name, 1'b1);
    // Disturb operands and pulse start mid-RUN; neither may take effect.
    while (!done && n < 60) begin
      if (busy) begin
        nbusy++;
        if (alu_control !== ctl) bad++;
      end
      src_a = $urandom;
      src_b = $urandom;
      op    = 2'($urandom_range(0, 3));
      start = (nbusy == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({name, "_done_seen"}, {31'b0, done}, 32'd1);
    check({name, "_busy_cycles"}, nbusy, 32);
    check({name, "_alu_ctl_bad"}, bad, 0);
    check({name, "_done_drive"}, {ready, busy, alu_control, 28'b0} | alu_op_a | alu_op_b, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_back_idle"}, {30'b0, ready, busy}, 32'd2);
  endtask

  initial begin : stim
    int n;
    int d;
    int ndone;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {26'b0, ready, busy, done, alu_control, 1'b0}, 32'h20);
    check("reset_result", result, 32'd0);

    run_op(2'b00, 32'd7, 32'd6, 32'h0000002A, "mul_7x6", 2'b00);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ff", 2'b00);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_ff", 2'b00);
    run_op(2'b10, 32'd100, 32'd7, 32'h0000000E, "divu_100_7", 2'b01);
    run_op(2'b11, 32'd100, 32'd7, 32'h00000002, "remu_100_7", 2'b01);
    run_op(2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, "divu_big", 2'b01);
    run_op(2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, "remu_big", 2'b01);
    run_op(2'b10, 32'h12345678, 32'd0, 32'hFFFFFFFF, "divu_zero", 2'b01);
    run_op(2'b11, 32'h12345678, 32'd0, 32'h12345678, "remu_zero", 2'b01);

    // Abort in the tenth RUN cycle.
    issue(2'b10, 32'd100, 32'd7, 32'd0, "abort", 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_to_idle", {29'b0, ready, busy, done}, 32'd4);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_result_kept", result, 32'h12345678);

    // Asynchronous reset mid-RUN.
    issue(2'b00, 32'd3, 32'd5, 32'd0, "rst", 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_flags", {26'b0, ready, busy, done, alu_control, 1'b0}, 32'h20);
    check("midrun_reset_result", result, 32'd0);
    check("midrun_reset_alu", alu_op_a | alu_op_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start held high across two operations.
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
    sb.push_back('{32'h0000000E, cyc + 1, "held1"});
    @(negedge clk);
    op = 2'b00; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("held1_done_seen", {31'b0, done}, 32'd1);
    d = cyc;
    sb.push_back('{32'h00000001, d + 2, "held2"});
    @(negedge clk);
    check("held_idle_cycle", {30'b0, ready, busy}, 32'd2);
    @(negedge clk);
    check("held_reaccept", {30'b0, ready, busy}, 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("held2_done_seen", {31'b0, done}, 32'd1);
    repeat (3) @(negedge clk);
    check("pending_results", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
